// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Brief    : Shared types and helpers for the instruction/data RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int c_DEFAULT_DEPTH = 256;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Byte address to full word index; callers keep the low AW bits.
    function automatic logic [29:0] word_of(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_starve_guard.sv
`default_nettype none
// ============================================================================
// Module   : rr_starve_guard
// Brief    : Data-priority read grant with an ifetch starvation counter.
// Revision : 1.0 - initial release
// ============================================================================
module rr_starve_guard #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_if_valid,
    input  logic i_d_valid,
    input  logic i_if_stall,
    output logic o_if_grant,
    output logic o_d_grant
);

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0] r_starve_cnt;

    assign o_if_grant = i_if_valid && (!i_d_valid || (r_starve_cnt == c_STARVE_MAX));
    assign o_d_grant  = i_d_valid && !o_if_grant;

    // A stalled ifetch grant neither counts as a loss nor as a win: hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (!i_if_valid || (o_if_grant && !i_if_stall)) begin
            r_starve_cnt <= 4'd0;
        end else if (o_d_grant && (r_starve_cnt != c_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Shares a 1W/1R word RAM between ifetch and data ports.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DEPTH      = c_DEFAULT_DEPTH,
    parameter int AW         = $clog2(DEPTH),
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req_valid,
    output logic          if_req_ready,
    input  logic [31:0]   if_addr,
    output logic          if_rsp_valid,
    output logic [31:0]   if_rsp_data,
    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_rsp_valid,
    output logic [31:0]   d_rsp_data,
    output logic [31:0]   ram_din,
    output logic [3:0]    ram_wen,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    input  logic [31:0]   ram_dout
);

    logic [29:0]   w_if_word;
    logic [29:0]   w_d_word;
    logic [AW-1:0] w_if_idx;
    logic [AW-1:0] w_d_idx;
    logic          w_write;
    logic          w_d_rd;
    logic          w_if_rd;
    logic          w_if_grant;
    logic          w_d_grant;
    logic          w_hazard;
    logic          w_if_acc;
    logic          w_unused_hi;
    owner_e        r_owner;

    assign w_if_word   = word_of(if_addr);
    assign w_d_word    = word_of(d_addr);
    assign w_if_idx    = w_if_word[AW-1:0];
    assign w_d_idx     = w_d_word[AW-1:0];
    assign w_unused_hi = ^{w_if_word[29:AW], w_d_word[29:AW]};

    // Qualifying with rst_n keeps every combinational output at 0 in reset.
    assign w_write = rst_n && d_req_valid && d_we;
    assign w_d_rd  = rst_n && d_req_valid && !d_we;
    assign w_if_rd = rst_n && if_req_valid;

    rr_starve_guard #(
        .STARVE_MAX (STARVE_MAX)
    ) u_guard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_if_valid (w_if_rd),
        .i_d_valid  (w_d_rd),
        .i_if_stall (w_hazard),
        .o_if_grant (w_if_grant),
        .o_d_grant  (w_d_grant)
    );

    // Only ifetch can collide with a write: a data port cannot read and write at once.
    assign w_hazard = w_if_grant && w_write && (d_be != 4'd0) && (w_if_idx == w_d_idx);
    assign w_if_acc = w_if_grant && !w_hazard;

    assign if_req_ready = w_if_acc;
    assign d_req_ready  = w_write || w_d_grant;

    assign ram_wen   = w_write ? d_be    : 4'd0;
    assign ram_din   = w_write ? d_wdata : 32'd0;
    assign ram_waddr = w_write ? w_d_idx : '0;
    assign ram_raddr = w_if_grant ? w_if_idx : (w_d_grant ? w_d_idx : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_NONE;
        end else if (w_if_acc) begin
            r_owner <= OWN_IF;
        end else if (w_d_grant) begin
            r_owner <= OWN_D;
        end else begin
            r_owner <= OWN_NONE;
        end
    end

    assign if_rsp_valid = (r_owner == OWN_IF);
    assign d_rsp_valid  = (r_owner == OWN_D);
    assign if_rsp_data  = if_rsp_valid ? ram_dout : 32'd0;
    assign d_rsp_data   = d_rsp_valid  ? ram_dout : 32'd0;

endmodule
`default_nettype wire
